unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Fetch stage of the Redux-V datapath. Owns the program counter and drives the
//  address of the combinational instruction memory. Latches the returned byte into
//  an instruction register and presents it, with its PC, to the decoder/control unit.
//  Two-phase BUSCA/EXECUTA sequencing with stall, absolute/relative branch and halt.
// PARAMETERS
//  PC_INICIAL  8'd0  PC value loaded on reset
// PORTS
//  clock          in   1  single system clock; all state updates on rising edge
//  reset          in   1  asynchronous, active-high; clears all state immediately
//  endereco       out  8  instruction-memory address (= PC)
//  instrucao_in   in   8  byte returned combinationally by instruction memory
//  instrucao_out  out  8  instruction register (IR) to decoder
//  pc_atual       out  8  address the IR content was fetched from
//  valido         out  1  1 while IR holds an instruction to execute (EXECUTA)
//  parar          in   1  stall request from control unit
//  desvio_abs     in   1  take absolute branch this cycle
//  alvo_abs       in   8  absolute branch target
//  desvio_rel     in   1  take PC-relative branch this cycle
//  deslocamento   in   4  signed two's-complement offset, -8..+7
//  halt           in   1  decoder has executed halt; stop fetching
//  parado         out  1  1 once halted
// BEHAVIOUR
//  - Reset (async): pc=PC_INICIAL, IR=0, pc_atual=0, estado=BUSCA, valido=0, parado=0.
//  - endereco = pc combinationally at all times; no other output is combinational.
//  - valido = (estado==EXECUTA); parado = (estado==PARADO); both decoded from the state reg.
//  - BUSCA: if parar=1 hold all state. Else at edge: IR<=instrucao_in, pc_atual<=pc,
//    estado<=EXECUTA. Branch/halt inputs are ignored in BUSCA.
//  - EXECUTA, priority at edge (highest first):
//      halt=1       -> estado<=PARADO, pc and IR held.
//      parar=1      -> hold all state (IR stays valid).
//      desvio_abs=1 -> pc<=alvo_abs.
//      desvio_rel=1 -> pc<=pc + sign_extend(deslocamento) (pc = address of current instr).
//      otherwise    -> pc<=pc+1.
//    Every non-held, non-halt case also sets estado<=BUSCA.
//  - PARADO: all registers frozen; valido=0; exit only via reset.
//  - Latency: one instruction every 2 cycles without stalls. IR valid the cycle after fetch.
//  - Arithmetic: 8-bit modulo 256; pc=8'hFF +1 -> 8'h00; pc=8'h02 + (-8) -> 8'hFA.
//  - Simultaneous desvio_abs and desvio_rel: absolute wins. halt beats every other input.
//  - Reset asserted mid-EXECUTA or in PARADO: returns to reset state at once; first
//    fetch after release is from PC_INICIAL.
//  - Unused state encoding -> BUSCA at next edge (pc held).
// TESTING
//  1 Reset, memory bytes 0..3 = B0,B5,BA,BF, no control inputs -> IR B0/pc_atual 0 after
//    edge 1, valido=1; endereco 1 after edge 2; IR B5/pc_atual 1 after edge 3; IR BF after edge 7.
//  2 PC_INICIAL=8'hFE, free run -> pc_atual sequence FE, FF, 00, 01 (wrap-around).
//  3 At pc_atual=5 assert desvio_rel, deslocamento=4'b1101 -> next pc_atual=2;
//    at pc_atual=2 with 4'b0111 -> next pc_atual=9; at 2 with 4'b1000 -> FA.
//  4 In EXECUTA assert desvio_abs (alvo_abs=8'h28) with desvio_rel (+3) -> next pc_atual=28.
//  5 parar=1 for 3 cycles in EXECUTA and in BUSCA -> IR, pc, valido unchanged
//    during stall; sequence resumes exactly where held; branch inputs in BUSCA ignored.
//  6 halt=1 with parar=1 and desvio_abs=1 -> parado=1, valido=0, pc frozen for 10 cycles;
//    reset pulse mid-cycle -> outputs clear before next edge, refetch from PC_INICIAL.

Source files
------------

// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - Redux-V fetch stage: PC, instruction register, BUSCA/EXECUTA/PARADO sequencing
module unidade_busca #(
  parameter logic [7:0] PC_INICIAL = 8'd0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] endereco,
  input  logic [7:0] instrucao_in,
  output logic [7:0] instrucao_out,
  output logic [7:0] pc_atual,
  output logic       valido,
  input  logic       parar,
  input  logic       desvio_abs,
  input  logic [7:0] alvo_abs,
  input  logic       desvio_rel,
  input  logic [3:0] deslocamento,
  input  logic       halt,
  output logic       parado
);

  typedef enum logic [1:0] {
    BUSCA   = 2'b00,
    EXECUTA = 2'b01,
    PARADO  = 2'b10
  } estado_t;

  estado_t    r_estado, w_prox_estado;
  logic [7:0] r_pc, w_prox_pc;
  logic [7:0] r_ir, w_prox_ir;
  logic [7:0] r_pc_atual, w_prox_pc_atual;
  logic [7:0] w_desl_ext;

  assign w_desl_ext = {{4{deslocamento[3]}}, deslocamento};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= BUSCA;
      r_pc       <= PC_INICIAL;
      r_ir       <= 8'h00;
      r_pc_atual <= 8'h00;
    end else begin
      r_estado   <= w_prox_estado;
      r_pc       <= w_prox_pc;
      r_ir       <= w_prox_ir;
      r_pc_atual <= w_prox_pc_atual;
    end
  end

  // In EXECUTA r_pc still equals the address of the instruction in IR,
  // so the relative target is computed from r_pc directly.
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_pc       = r_pc;
    w_prox_ir       = r_ir;
    w_prox_pc_atual = r_pc_atual;
    case (r_estado)
      BUSCA: begin
        if (!parar) begin
          w_prox_ir       = instrucao_in;
          w_prox_pc_atual = r_pc;
          w_prox_estado   = EXECUTA;
        end
      end
      EXECUTA: begin
        if (halt) begin
          w_prox_estado = PARADO;
        end else if (!parar) begin
          w_prox_estado = BUSCA;
          if (desvio_abs)      w_prox_pc = alvo_abs;
          else if (desvio_rel) w_prox_pc = r_pc + w_desl_ext;
          else                 w_prox_pc = r_pc + 8'd1;
        end
      end
      PARADO: begin
        w_prox_estado = PARADO;
      end
      default: begin
        w_prox_estado = BUSCA;
      end
    endcase
  end

  assign endereco      = r_pc;
  assign instrucao_out = r_ir;
  assign pc_atual      = r_pc_atual;
  assign valido        = (r_estado == EXECUTA);
  assign parado        = (r_estado == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - directed bench for unidade_busca with a combinational memory model
module tb_unidade_busca;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reset_b = 1'b1;
  logic [7:0] mem [256];

  logic [7:0] end_a, ir_a, pca_a, instr_a;
  logic       val_a, par_a;
  logic       parar = 1'b0, d_abs = 1'b0, d_rel = 1'b0, halt = 1'b0;
  logic [7:0] alvo = 8'h00;
  logic [3:0] desl = 4'h0;

  logic [7:0] end_b, ir_b, pca_b, instr_b;
  logic       val_b, par_b;

  int total = 0;
  int passou = 0;

  always #5 clock = ~clock;

  assign instr_a = mem[end_a];
  assign instr_b = mem[end_b];

  unidade_busca u_a (
    .clock(clock), .reset(reset), .endereco(end_a), .instrucao_in(instr_a),
    .instrucao_out(ir_a), .pc_atual(pca_a), .valido(val_a), .parar(parar),
    .desvio_abs(d_abs), .alvo_abs(alvo), .desvio_rel(d_rel), .deslocamento(desl),
    .halt(halt), .parado(par_a)
  );

  unidade_busca #(.PC_INICIAL(8'hFE)) u_b (
    .clock(clock), .reset(reset_b), .endereco(end_b), .instrucao_in(instr_b),
    .instrucao_out(ir_b), .pc_atual(pca_b), .valido(val_b), .parar(1'b0),
    .desvio_abs(1'b0), .alvo_abs(8'h00), .desvio_rel(1'b0), .deslocamento(4'h0),
    .halt(1'b0), .parado(par_b)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    else passou++;
  endtask

  task automatic ciclo();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic limpa();
    parar = 1'b0; d_abs = 1'b0; d_rel = 1'b0; halt = 1'b0; alvo = 8'h00; desl = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'hB0; mem[1] = 8'hB5; mem[2] = 8'hBA; mem[3] = 8'hBF;

    // Reset state
    @(negedge clock);
    verifica("rst_end", end_a, 8'h00);
    verifica("rst_ir", ir_a, 8'h00);
    verifica("rst_pca", pca_a, 8'h00);
    verifica("rst_val", val_a, 1'b0);
    verifica("rst_par", par_a, 1'b0);
    reset = 1'b0;

    // Free run from 0
    ciclo();
    verifica("t1_ir0", ir_a, 8'hB0);
    verifica("t1_pca0", pca_a, 8'h00);
    verifica("t1_val1", val_a, 1'b1);
    ciclo();
    verifica("t1_end1", end_a, 8'h01);
    verifica("t1_val0", val_a, 1'b0);
    ciclo();
    verifica("t1_ir1", ir_a, 8'hB5);
    verifica("t1_pca1", pca_a, 8'h01);
    ciclo(); ciclo();
    verifica("t1_ir2", ir_a, 8'hBA);
    ciclo(); ciclo();
    verifica("t1_ir3", ir_a, 8'hBF);
    verifica("t1_pca3", pca_a, 8'h03);

    // Relative branches, incl. negative offsets and wrap below zero
    d_abs = 1'b1; alvo = 8'h05; ciclo(); limpa(); ciclo();
    verifica("t3_pca5", pca_a, 8'h05);
    verifica("t3_ir5", ir_a, mem[5]);
    d_rel = 1'b1; desl = 4'b1101; ciclo();
    verifica("t3_end2", end_a, 8'h02);
    limpa(); ciclo();
    verifica("t3_pca2", pca_a, 8'h02);
    d_rel = 1'b1; desl = 4'b0111; ciclo(); limpa(); ciclo();
    verifica("t3_pca9", pca_a, 8'h09);
    d_abs = 1'b1; alvo = 8'h02; ciclo(); limpa(); ciclo();
    d_rel = 1'b1; desl = 4'b1000; ciclo(); limpa(); ciclo();
    verifica("t3_pcaFA", pca_a, 8'hFA);
    verifica("t3_irFA", ir_a, mem[8'hFA]);

    // Absolute beats relative
    d_abs = 1'b1; alvo = 8'h28; d_rel = 1'b1; desl = 4'b0011; ciclo(); limpa(); ciclo();
    verifica("t4_pca28", pca_a, 8'h28);

    // Stall in EXECUTA
    parar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verifica("t5_ex_ir", ir_a, mem[8'h28]);
      verifica("t5_ex_end", end_a, 8'h28);
      verifica("t5_ex_val", val_a, 1'b1);
    end
    parar = 1'b0; ciclo();
    verifica("t5_end29", end_a, 8'h29);
    // Stall in BUSCA with branch inputs that must be ignored
    parar = 1'b1; d_abs = 1'b1; alvo = 8'h77;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verifica("t5_bu_val", val_a, 1'b0);
      verifica("t5_bu_end", end_a, 8'h29);
      verifica("t5_bu_pca", pca_a, 8'h28);
    end
    parar = 1'b0; d_rel = 1'b1; desl = 4'b0101; ciclo();
    verifica("t5_pca29", pca_a, 8'h29);
    verifica("t5_ir29", ir_a, mem[8'h29]);
    verifica("t5_val", val_a, 1'b1);
    limpa(); ciclo();
    verifica("t5_end2A", end_a, 8'h2A);

    // Halt wins over stall and branch
    ciclo();
    verifica("t6_pca2A", pca_a, 8'h2A);
    halt = 1'b1; parar = 1'b1; d_abs = 1'b1; alvo = 8'h10;
    for (int i = 0; i < 10; i++) begin
      ciclo();
      verifica("t6_par", par_a, 1'b1);
      verifica("t6_val", val_a, 1'b0);
      verifica("t6_end", end_a, 8'h2A);
      if (i == 4) limpa();
    end
    verifica("t6_ir", ir_a, mem[8'h2A]);
    #2 reset = 1'b1;
    #1;
    verifica("t6_rst_end", end_a, 8'h00);
    verifica("t6_rst_ir", ir_a, 8'h00);
    verifica("t6_rst_par", par_a, 1'b0);
    verifica("t6_rst_pca", pca_a, 8'h00);
    #1 reset = 1'b0;
    ciclo();
    verifica("t6_ir0", ir_a, 8'hB0);
    verifica("t6_val1", val_a, 1'b1);

    // PC_INICIAL = FE wraps through 00
    reset_b = 1'b0;
    ciclo();
    verifica("t2_pcaFE", pca_b, 8'hFE);
    verifica("t2_irFE", ir_b, mem[8'hFE]);
    ciclo(); ciclo();
    verifica("t2_pcaFF", pca_b, 8'hFF);
    ciclo(); ciclo();
    verifica("t2_pca00", pca_b, 8'h00);
    verifica("t2_ir00", ir_b, 8'hB0);
    ciclo(); ciclo();
    verifica("t2_pca01", pca_b, 8'h01);

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
